// File: rtl/trivium_stream_ctrl_if.sv
// Requester-side handshake bundle for trivium_stream_ctrl: two byte requesters
// sharing one registered ciphertext return path.
interface trivium_stream_ctrl_if;
  logic       req0;
  logic       req1;
  logic [7:0] pt0;
  logic [7:0] pt1;
  logic       ack0;
  logic       ack1;
  logic [7:0] ct;

  modport master (output req0, req1, pt0, pt1, input ack0, ack1, ct);
  modport slave  (input req0, req1, pt0, pt1, output ack0, ack1, ct);
endinterface

// File: rtl/trivium_stream_ctrl.sv
// Sequences a Trivium keystream core (load, warm-up, 8-bit harvest) and serves
// two round-robin byte requesters. Define TRIVIUM_CTRL_REKEY_EN for automatic re-keying.
module trivium_stream_ctrl #(
  parameter int WARMUP_CYCLES = 1152,
  parameter int REKEY_BYTES   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  core_rst_n,
  output logic                  core_en,
  input  logic                  core_ks_bit,
  output logic                  ready,
  output logic                  busy,
  trivium_stream_ctrl_if.slave  bus
);

  localparam int CNT_W = ($clog2(WARMUP_CYCLES + 1) > 11) ? $clog2(WARMUP_CYCLES + 1) : 11;
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(7);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(8);

  if (WARMUP_CYCLES < 1) begin : g_bad_warmup
    $error("WARMUP_CYCLES must be at least 1");
  end
  if (REKEY_BYTES < 1) begin : g_bad_rekey
    $error("REKEY_BYTES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, WARMUP, READY, SHIFT, RESPOND} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             prio1;   // set when req1 wins the next tie
  logic             gnt;
  logic             pick;
  logic [7:0]       pt_q;
  logic [6:0]       ks_sr;
  logic [7:0]       ct_next;

  assign pick    = bus.req1 && (!bus.req0 || prio1);
  assign ct_next = pt_q ^ {core_ks_bit, ks_sr};

`ifdef TRIVIUM_CTRL_REKEY_EN
  localparam int BC_W = ($clog2(REKEY_BYTES + 1) > 1) ? $clog2(REKEY_BYTES + 1) : 1;
  logic [BC_W-1:0] byte_cnt;
  logic            rekey_due;
  assign rekey_due = (byte_cnt == BC_W'(REKEY_BYTES - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, data latches included, is reset so ct and the core
      // controls are defined straight out of reset.
      state      <= IDLE;
      core_rst_n <= 1'b0;
      core_en    <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.ct     <= '0;
      cnt        <= '0;
      prio1      <= 1'b0;
      gnt        <= 1'b0;
      pt_q       <= '0;
      ks_sr      <= '0;
`ifdef TRIVIUM_CTRL_REKEY_EN
      byte_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking only; a later assignment in the taken branch overrides
      // these per-cycle defaults.
      core_rst_n <= 1'b1;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.ct     <= '0;
      if (start && state != LOAD) begin
        state      <= LOAD;
        core_rst_n <= 1'b0;
        core_en    <= 1'b0;
        ready      <= 1'b0;
        busy       <= 1'b1;
`ifdef TRIVIUM_CTRL_REKEY_EN
        byte_cnt   <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: ;
          LOAD: begin
            state   <= WARMUP;
            core_en <= 1'b1;
            cnt     <= '0;
          end
          WARMUP: begin
            if (cnt == WARM_LAST) begin
              state   <= READY;
              core_en <= 1'b0;
              ready   <= 1'b1;
              busy    <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          READY: begin
            if (bus.req0 || bus.req1) begin
              gnt     <= pick;
              prio1   <= !pick;
              pt_q    <= pick ? bus.pt1 : bus.pt0;
              state   <= SHIFT;
              core_en <= 1'b1;
              ready   <= 1'b0;
              busy    <= 1'b1;
              cnt     <= '0;
            end
          end
          SHIFT: begin
            // The shift in the first SHIFT cycle is garbage; seven later shifts flush it.
            ks_sr <= {core_ks_bit, ks_sr[6:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == EN_LAST) core_en <= 1'b0;
            if (cnt == SHIFT_LAST) begin
              state    <= RESPOND;
              bus.ack0 <= !gnt;
              bus.ack1 <= gnt;
              bus.ct   <= ct_next;
            end
          end
          RESPOND: begin
`ifdef TRIVIUM_CTRL_REKEY_EN
            if (rekey_due) begin
              state      <= LOAD;
              core_rst_n <= 1'b0;
              byte_cnt   <= '0;
            end else begin
              state    <= READY;
              ready    <= 1'b1;
              busy     <= 1'b0;
              byte_cnt <= byte_cnt + 1'b1;
            end
`else
            state <= READY;
            ready <= 1'b1;
            busy  <= 1'b0;
`endif
          end
          default: begin
            state   <= IDLE;
            core_en <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Self-checking bench for trivium_stream_ctrl: a phase/elapsed-cycle model predicts
// every output each cycle, plus directed literal checks of timing and ciphertext.
module tb_trivium_stream_ctrl;

  localparam int W  = 1152;
  localparam int RK = 2;
`ifdef TRIVIUM_CTRL_REKEY_EN
  localparam bit REKEY_ON = 1'b1;
`else
  localparam bit REKEY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_ks_bit = 1'b0;
  logic core_rst_n, core_en, ready, busy;

  trivium_stream_ctrl_if bus();

  trivium_stream_ctrl #(.WARMUP_CYCLES(W), .REKEY_BYTES(RK)) dut (
    .clk(clk), .rst(rst), .start(start),
    .core_rst_n(core_rst_n), .core_en(core_en), .core_ks_bit(core_ks_bit),
    .ready(ready), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: which phase we are in and how many edges have elapsed since it began.
  typedef enum int {M_IDLE, M_INIT, M_READY, M_SERVE} phase_t;
  phase_t     ph;
  int         t;
  bit         last;     // requester granted most recently
  bit         who;
  logic [7:0] mpt;
  logic [7:0] kbyte;
  int         served;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ph = M_IDLE; t = 0; last = 1'b1; who = 1'b0; mpt = '0; kbyte = '0; served = 0;
  endfunction

  function automatic void model_edge(input logic s, input logic r0, input logic r1,
                                     input logic [7:0] p0, input logic [7:0] p1, input logic ks);
    if (s && !(ph == M_INIT && t == 0)) begin
      ph = M_INIT; t = 0; served = 0;
    end else begin
      case (ph)
        M_INIT: begin
          t++;
          if (t == W + 1) ph = M_READY;
        end
        M_READY: begin
          if (r0 || r1) begin
            who   = (r0 && r1) ? !last : r1;
            last  = who;
            mpt   = who ? p1 : p0;
            kbyte = '0;
            t     = 0;
            ph    = M_SERVE;
          end
        end
        M_SERVE: begin
          t++;
          if (t >= 2 && t <= 9) kbyte[3'(t - 2)] = ks;
          if (t == 10) begin
            served++;
            if (REKEY_ON && served == RK) begin
              ph = M_INIT; t = 0; served = 0;
            end else begin
              ph = M_READY;
            end
          end
        end
        default: ;
      endcase
    end
  endfunction

  // {core_rst_n, core_en, ready, busy, ack0, ack1, ct}
  function automatic logic [13:0] model_out();
    logic [13:0] o;
    o = '0;
    case (ph)
      M_IDLE:  o[13] = 1'b1;
      M_INIT:  begin o[13] = (t != 0); o[12] = (t != 0); o[10] = 1'b1; end
      M_READY: begin o[13] = 1'b1; o[11] = 1'b1; end
      M_SERVE: begin
        o[13] = 1'b1;
        o[12] = (t <= 7);
        o[10] = 1'b1;
        if (t == 9) begin
          o[9]   = !who;
          o[8]   = who;
          o[7:0] = mpt ^ kbyte;
        end
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [13:0] dut_out();
    return {core_rst_n, core_en, ready, busy, bus.ack0, bus.ack1, bus.ct};
  endfunction

  task automatic cycle();
    logic s, r0, r1, ks;
    logic [7:0] p0, p1;
    s = start; r0 = bus.req0; r1 = bus.req1; p0 = bus.pt0; p1 = bus.pt1; ks = core_ks_bit;
    @(posedge clk);
    model_edge(s, r0, r1, p0, p1, ks);
    #1;
    check("cycle_outputs", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      cycle();
      n++;
    end
    check("wait_ready", 32'(ready), 32'd1);
  endtask

  task automatic drive_random();
    start = ($urandom_range(1999) == 0);
    core_ks_bit = 1'($urandom_range(1));
    if (bus.ack0) begin
      if ($urandom_range(1) == 1) bus.pt0 = 8'($urandom); else bus.req0 = 1'b0;
    end else if (!bus.req0) begin
      if ($urandom_range(7) == 0) begin bus.req0 = 1'b1; bus.pt0 = 8'($urandom); end
    end else if (!(ph == M_SERVE && !who) && $urandom_range(63) == 0) begin
      bus.req0 = 1'b0;
    end
    if (bus.ack1) begin
      if ($urandom_range(1) == 1) bus.pt1 = 8'($urandom); else bus.req1 = 1'b0;
    end else if (!bus.req1) begin
      if ($urandom_range(7) == 0) begin bus.req1 = 1'b1; bus.pt1 = 8'($urandom); end
    end else if (!(ph == M_SERVE && who) && $urandom_range(63) == 0) begin
      bus.req1 = 1'b0;
    end
  endtask

  int rel, rst_lo, rst_at, en_first, en_last, en_cnt, rdy_at;
  int a0, a1, overlap, ack_rel, n_ack;
  int at [3];
  logic [7:0] pat;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.pt0 = '0; bus.pt1 = '0;
    model_reset();
    #2;
    check("reset_outputs", 32'(dut_out()), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle();

    // Start at cycle 0: one LOAD cycle, W enabled cycles, READY at W+2.
    start = 1'b1; cycle(); start = 1'b0;
    rel = 1; rst_lo = 0; rst_at = -1; en_first = -1; en_last = -1; en_cnt = 0; rdy_at = -1;
    while (rel <= W + 100) begin
      if (!core_rst_n) begin rst_lo++; rst_at = rel; end
      if (core_en) begin
        if (en_first < 0) en_first = rel;
        en_last = rel;
        en_cnt++;
      end
      if (ready) begin rdy_at = rel; break; end
      cycle();
      rel++;
    end
    check("load_low_cycles", 32'(rst_lo), 32'd1);
    check("load_cycle", 32'(rst_at), 32'd1);
    check("warm_first_en", 32'(en_first), 32'd2);
    check("warm_last_en", 32'(en_last), 32'd1153);
    check("warm_en_count", 32'(en_cnt), 32'd1152);
    check("ready_cycle", 32'(rdy_at), 32'd1154);

    // Both requesters at once from a fresh pointer: req0 then req1, 11 cycles apart.
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.pt0 = 8'h00; bus.pt1 = 8'h00;
    rel = 0; a0 = -1; a1 = -1; overlap = 0;
    while (rel < 60 && (a0 < 0 || a1 < 0)) begin
      core_ks_bit = 1'($urandom_range(1));
      cycle();
      rel++;
      if (bus.ack0 && bus.ack1) overlap++;
      if (bus.ack0 && a0 < 0) begin a0 = rel; bus.req0 = 1'b0; end
      if (bus.ack1 && a1 < 0) begin a1 = rel; bus.req1 = 1'b0; end
    end
    check("tie_ack0_cycle", 32'(a0), 32'd10);
    check("tie_ack1_cycle", 32'(a1), 32'd21);
    check("tie_overlap", 32'(overlap), 32'd0);

    // Keystream 1,0,1,1,0,0,0,1 (LSB first = 8'h8D) against pt0=FF gives ct=8'h72.
    wait_ready(W + 50);
    bus.req0 = 1'b1; bus.pt0 = 8'hFF;
    pat = 8'h8D;
    cycle();
    core_ks_bit = 1'b0;
    cycle();
    for (int i = 0; i < 8; i++) begin
      core_ks_bit = pat[i];
      cycle();
    end
    check("pattern_ack0", 32'(bus.ack0), 32'd1);
    check("pattern_ack1", 32'(bus.ack1), 32'd0);
    check("pattern_ct", 32'(bus.ct), 32'h72);
    bus.req0 = 1'b0;
    cycle();
    check("ct_idle_zero", 32'(bus.ct), 32'd0);

    // Abort at G+5: LOAD at G+6, full warm-up, then the pending request at G+W+17.
    wait_ready(W + 50);
    bus.req0 = 1'b1; bus.pt0 = 8'h5A;
    repeat (5) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    check("abort_load", 32'(core_rst_n), 32'd0);
    rel = 6; ack_rel = -1;
    while (rel < W + 60) begin
      cycle();
      rel++;
      if (bus.ack0 || bus.ack1) begin ack_rel = rel; break; end
    end
    check("abort_ack_cycle", 32'(ack_rel), 32'(W + 17));
    bus.req0 = 1'b0;

    // Three back-to-back req0 bytes after a fresh start.
    start = 1'b1; cycle(); start = 1'b0;
    wait_ready(W + 50);
    bus.req0 = 1'b1; bus.pt0 = 8'($urandom);
    rel = 0; n_ack = 0; at[0] = -1; at[1] = -1; at[2] = -1;
    while (rel < 2 * W + 200 && n_ack < 3) begin
      core_ks_bit = 1'($urandom_range(1));
      cycle();
      rel++;
      if (bus.ack0) begin
        at[n_ack] = rel;
        n_ack++;
        bus.pt0 = 8'($urandom);
      end
    end
    bus.req0 = 1'b0;
    check("rekey_ack_count", 32'(n_ack), 32'd3);
    check("rekey_gap12", 32'(at[1] - at[0]), 32'd11);
    check("rekey_gap23", 32'(at[2] - at[1]), REKEY_ON ? 32'(W + 12) : 32'd11);

    // Random traffic, drops and occasional restarts, checked every cycle.
    wait_ready(W + 50);
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      cycle();
    end
    start = 1'b0;

    // Asynchronous reset mid-run.
    #3;
    rst = 1'b0;
    #1;
    check("async_reset", 32'(dut_out()), 32'h0);
    model_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cycle();
    start = 1'b1; cycle(); start = 1'b0;
    wait_ready(W + 50);
    bus.req1 = 1'b1; bus.pt1 = 8'h3C;
    for (int i = 0; i < 12; i++) begin
      core_ks_bit = 1'($urandom_range(1));
      cycle();
      if (bus.ack1) bus.req1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trivium_stream_ctrl.md
TRIVIUM_STREAM_CTRL -- requirements
Module: trivium_stream_ctrl

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 1152, number of core enable cycles discarded after each key/IV load.
REQ-002 SHALL have parameter REKEY_BYTES, default 1024, bytes served before automatic re-initialization (used only with TRIVIUM_CTRL_REKEY_EN).
REQ-003 SHALL have port clk input 1, clock.
REQ-004 SHALL have port rst input 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start input 1, single-cycle pulse that (re)initializes the keystream core.
REQ-006 SHALL have port core_rst_n output 1, active-low reset driven to the keystream core.
REQ-007 SHALL have port core_en output 1, enable driven to the keystream core.
REQ-008 SHALL have port core_ks_bit input 1, registered keystream bit from the core, valid one cycle after each core_en cycle.
REQ-009 SHALL have ports req0, req1 input 1 each, requester byte requests, held high until the matching ack.
REQ-010 SHALL have ports pt0, pt1 input 8 each, requester plaintext bytes, stable while the matching req is high.
REQ-011 SHALL have ports ack0, ack1 output 1 each, single-cycle completion pulses.
REQ-012 SHALL have port ct output 8, ciphertext, valid only in the cycle either ack is high.
REQ-013 SHALL have ports ready output 1 (state READY) and busy output 1 (any state other than IDLE or READY).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WARMUP, READY, SHIFT, RESPOND; reset state IDLE.
REQ-015 IDLE -> LOAD on start; LOAD lasts exactly 1 cycle with core_rst_n=0, core_en=0.
REQ-016 WARMUP SHALL hold core_en=1 for exactly WARMUP_CYCLES cycles (11-bit counter minimum, sized from parameter), then -> READY; core_ks_bit ignored.
REQ-017 In READY, if any req is high, SHALL grant one requester, latch its pt, go to SHIFT; grant cycle = G.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; pointer resets so req0 wins first.
REQ-019 SHIFT SHALL last 9 cycles (G+1..G+9): core_en=1 in G+1..G+8 only; core_ks_bit sampled in G+2..G+9, first sample to bit 0 (LSB first).
REQ-020 RESPOND (cycle G+10) SHALL pulse the granted ack, drive ct = latched pt XOR collected byte, then -> READY.
REQ-021 core_en SHALL be 0 in IDLE, LOAD, READY, RESPOND; core_rst_n SHALL be 1 in every state except LOAD.
REQ-022 start in any state other than LOAD SHALL abort the current operation (no ack for an in-flight byte) and enter LOAD next cycle; grant pointer unchanged.
REQ-023 Requests arriving outside READY SHALL remain pending and be arbitrated on the next READY cycle; a request dropped before grant is ignored.
REQ-024 ack0 and ack1 SHALL never be high together; ct SHALL be 0 when no ack is high.

Reset
REQ-025 On rst low: state IDLE, core_rst_n=0, core_en=0, ack0=ack1=0, ct=0, ready=0, busy=0, counters and grant pointer cleared.
REQ-026 After rst deasserts, core_rst_n SHALL be 1 from the first clock edge and the block SHALL wait in IDLE for start.

Configuration
REQ-027 With macro TRIVIUM_CTRL_REKEY_EN defined, a byte counter SHALL count RESPOND cycles; on reaching REKEY_BYTES the FSM SHALL go RESPOND -> LOAD instead of READY and clear the counter.
REQ-028 Without TRIVIUM_CTRL_REKEY_EN, no byte counter SHALL exist and RESPOND always -> READY.
REQ-029 start SHALL clear the byte counter when the feature is compiled in.

Verification
REQ-030 Reset, start pulse at cycle 0 -> core_rst_n=0 at cycle 1 only, core_en high cycles 2..1153, ready=1 at cycle 1154.
REQ-031 core_ks_bit model driving 1,0,1,1,0,0,0,1 after grant, req0 with pt0=8'hFF -> ack0 at G+10, ct=8'h72.
REQ-032 req0 and req1 high together from READY, pt0=8'h00, pt1=8'h00 -> ack0 first, then ack1 11 cycles later, never overlapping.
REQ-033 start pulsed at G+5 during SHIFT -> no ack, core_rst_n=0 next cycle, full WARMUP repeated, pending req served afterwards.
REQ-034 With TRIVIUM_CTRL_REKEY_EN and REKEY_BYTES=2, three back-to-back req0 bytes -> after second ack, LOAD and WARMUP run before third ack; without macro, no re-load.
